// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and the
// rule that decides whether a request gets an error response.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    // Misaligned or beyond the last word both produce an error response.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Synchronous single-port word RAM with per-byte write enables and a registered
// read port. Contents are never reset.
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, then holds the response until the CPU takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_e state_q;
    logic [3:0]  cnt_q;
    logic        lat_we_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic [3:0]  lat_be_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        rsp_load_q;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic        enter_resp;
    logic        bank_en;
    logic [31:0] bank_rdata;

    // With zero wait states the memory access happens on the accept edge itself,
    // so the bank must see the live request rather than the latched copy.
    always_comb begin
        if (state_q == StIdle) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = lat_we_q;
            cur_addr  = lat_addr_q;
            cur_wdata = lat_wdata_q;
            cur_be    = lat_be_q;
        end
        cur_err    = addr_err(cur_addr, DEPTH_WORDS);
        enter_resp = ((state_q == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == StWait) && (cnt_q == 4'd0));
        bank_en    = enter_resp && !cur_err && reset;
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .we   (cur_we),
        .be   (cur_be),
        .addr (cur_addr[AW+1:2]),
        .wdata(cur_wdata),
        .rdata(bank_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 32'h0;
            lat_wdata_q <= 32'h0;
            lat_be_q    <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        lat_we_q    <= req_we;
                        lat_addr_q  <= req_addr;
                        lat_wdata_q <= req_wdata;
                        lat_be_q    <= req_be;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= cur_err;
                            rsp_load_q  <= !cur_we && !cur_err;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= cur_err;
                        rsp_load_q  <= !cur_we && !cur_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_load_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // The bank output register holds the word fetched on entry to RESP.
    assign rsp_rdata = rsp_load_q ? bank_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and one
// with none, sharing clock and reset.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_valid, a_ready, a_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_addr, a_wdata, a_rsp_rdata;
    logic [3:0]  a_be;
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_addr, b_wdata, b_rsp_rdata;
    logic [3:0]  b_be;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    logic [31:0] mem_a[int];
    logic [31:0] mem_b[int];
    int          checks = 0;
    int          failures = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err)
    );

    // Reference memory: computes the expected response and applies stores.
    task automatic model(input bit which, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
        int idx;
        logic [31:0] w;
        e.rdata = 32'h0;
        e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        idx     = int'(addr[31:2]);
        if (!e.err) begin
            w = 32'h0;
            if (which) begin
                if (mem_b.exists(idx)) w = mem_b[idx];
            end else if (mem_a.exists(idx)) begin
                w = mem_a[idx];
            end
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                if (which) mem_b[idx] = w;
                else mem_a[idx] = w;
            end else begin
                e.rdata = w;
            end
        end
    endtask

    // One transaction on the two-wait-state instance. hold: cycles with rsp_ready
    // low in RESP; early: rsp_ready raised during WAIT; junk: drive a bogus store
    // while busy.
    task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, input bit early, input bit junk,
                         output logic [31:0] got);
        exp_t e;
        int cyc;
        model(1'b0, we, addr, wdata, be, e);
        sb_a.push_back(e);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
        @(posedge clk); #1;
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0) begin
            failures++; $display("FAIL a_busy_after_accept req_ready=%b exp=0", a_ready);
        end
        if (early) a_rsp_ready = 1'b1;
        if (junk) begin
            a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'hBAD0BAD0; a_be = 4'hF;
        end
        cyc = 1;
        while (a_rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (a_rsp_valid !== 1'b1 || cyc != 3) begin
            failures++; $display("FAIL a_latency cycles=%0d exp=3 rsp_valid=%b", cyc, a_rsp_valid);
        end
        e = sb_a.pop_front();
        got = a_rsp_rdata;
        checks++;
        if (a_rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL a_rdata addr=%h got=%h exp=%h", addr, a_rsp_rdata, e.rdata);
        end
        checks++;
        if (a_rsp_err !== e.err) begin
            failures++; $display("FAIL a_err addr=%h got=%b exp=%b", addr, a_rsp_err, e.err);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== e.rdata || a_rsp_err !== e.err ||
                a_ready !== 1'b0) begin
                failures++;
                $display("FAIL a_stall cyc=%0d valid=%b rdata=%h err=%b ready=%b exp 1/%h/%b/0",
                         h, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_ready, e.rdata, e.err);
            end
        end
        a_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        checks++;
        if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL a_idle_after_hs req_ready=%b rsp_valid=%b exp 1/0", a_ready, a_rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_rsp_ready = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_ready, a_rsp_valid, a_rsp_err} !== 3'b100 || a_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_a ready/valid/err=%b%b%b rdata=%h exp 100/0",
                     a_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata);
        end
        checks++;
        if ({b_ready, b_rsp_valid, b_rsp_err} !== 3'b100 || b_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_b ready/valid/err=%b%b%b rdata=%h exp 100/0",
                     b_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release ready=%b valid=%b exp 1/0", a_ready, a_rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] got;
        a_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0, got);
        a_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            failures++; $display("FAIL store_load got=%h exp=deadbeef", got);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] got;
        a_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, 1'b0, got);
        a_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, 1'b0, got);
        a_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        checks++;
        if (got !== 32'h11BB33DD) begin
            failures++; $display("FAIL byte_enable got=%h exp=11bb33dd", got);
        end
        a_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, 1'b0, got);
        a_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        checks++;
        if (got !== 32'h11BB33DD) begin
            failures++; $display("FAIL be_zero got=%h exp=11bb33dd", got);
        end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        a_txn(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b1, 1'b0, got);
        a_txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        a_txn(1'b1, 32'h22, 32'h55667788, 4'hF, 0, 1'b0, 1'b0, got);
        a_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        checks++;
        if (got !== 32'h11BB33DD) begin
            failures++; $display("FAIL err_store_no_write got=%h exp=11bb33dd", got);
        end
    endtask

    task automatic test_stall();
        logic [31:0] got;
        a_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, 1'b1, got);
        a_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        checks++;
        if (got !== 32'h11BB33DD) begin
            failures++; $display("FAIL busy_req_ignored got=%h exp=11bb33dd", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        a_txn(1'b1, 32'h30, 32'h12345678, 4'hF, 0, 1'b0, 1'b0, got);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'hCAFEF00D; a_be = 4'hF;
        @(posedge clk); #1;
        a_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset ready=%b valid=%b rdata=%h exp 1/0/0",
                     a_ready, a_rsp_valid, a_rsp_rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL after_mid_reset ready=%b valid=%b exp 1/0", a_ready, a_rsp_valid);
        end
        a_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 1'b0, got);
        checks++;
        if (got !== 32'h12345678) begin
            failures++; $display("FAIL abandoned_store got=%h exp=12345678", got);
        end
    endtask

    task automatic test_back_to_back();
        logic        we_t[7]    = '{1, 1, 1, 0, 0, 0, 0};
        logic [31:0] addr_t[7]  = '{32'h40, 32'h44, 32'h44, 32'h40, 32'h44, 32'h46, 32'h400};
        logic [31:0] data_t[7]  = '{32'hA5A5A5A5, 32'h01020304, 32'hFFEEDDCC, 0, 0, 0, 0};
        logic [3:0]  be_t[7]    = '{4'hF, 4'hF, 4'b1100, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_t e;
        b_rsp_ready = 1'b1;
        b_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            b_we = we_t[k]; b_addr = addr_t[k]; b_wdata = data_t[k]; b_be = be_t[k];
            model(1'b1, we_t[k], addr_t[k], data_t[k], be_t[k], e);
            sb_b.push_back(e);
            checks++;
            if (b_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle k=%0d ready=%b valid=%b exp 1/0", k, b_ready, b_rsp_valid);
            end
            @(posedge clk); #1;
            e = sb_b.pop_front();
            checks++;
            if (b_rsp_valid !== 1'b1 || b_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_resp k=%0d valid=%b ready=%b exp 1/0", k, b_rsp_valid, b_ready);
            end
            checks++;
            if (b_rsp_rdata !== e.rdata || b_rsp_err !== e.err) begin
                failures++;
                $display("FAIL b2b_data k=%0d rdata=%h err=%b exp %h/%b",
                         k, b_rsp_rdata, b_rsp_err, e.rdata, e.err);
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        checks++;
        if (mem_b[17] !== 32'hFFEE0304) begin
            failures++; $display("FAIL b2b_model_word got=%h exp=ffee0304", mem_b[17]);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  the CPU presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i); ignored for loads.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  the CPU accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errored requests.
REQ-014 SHALL have port rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP, with only one request outstanding at a time.
REQ-016 SHALL drive req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a clock edge where req_valid && req_ready, and SHALL latch we, addr, wdata and be at that edge.
REQ-018 SHALL move from IDLE to WAIT on accept when WAIT_CYCLES > 0, otherwise directly to RESP.
REQ-019 SHALL load a down-counter with WAIT_CYCLES-1 on entry to WAIT, decrement it each cycle, and go to RESP on the edge where it equals 0.
REQ-020 SHALL therefore assert rsp_valid exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 SHALL keep rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge; no new accept occurs in the same cycle.
REQ-022 SHALL flag an error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-023 SHALL perform the store on the edge entering RESP, writing only the enabled bytes; an errored store SHALL write nothing.
REQ-024 SHALL capture the load rsp_rdata on the edge entering RESP, as the full word at index addr[31:2].
REQ-025 SHALL let a store with be = 4'b0000 complete normally with rsp_err = 0 and leave memory unchanged.
REQ-026 SHALL ignore req_valid and the request inputs while in WAIT or RESP.
REQ-027 SHALL ignore rsp_ready outside RESP.
REQ-028 SHALL keep rsp_valid = 0 in IDLE and WAIT.

Reset
REQ-029 SHALL, while reset = 0, force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready is therefore 1 immediately after release.
REQ-030 SHALL abandon any in-flight request on reset assertion mid-operation; a pending store in WAIT SHALL NOT be written.
REQ-031 SHALL NOT reset the storage array; its contents are undefined after power-up and preserved across reset.

Structure
REQ-032 SHALL place the FSM state encoding and the response-error definition in the shared CPU package.
REQ-033 SHALL use one sub-module, dmem_bank: a synchronous single-port byte-enable word RAM of DEPTH_WORDS x 32.
REQ-034 SHALL keep the FSM, counter and error check in dmem_responder.

Verification
REQ-035 SHALL cover: WAIT_CYCLES = 2, store addr 0x10, data 0xDEADBEEF, be 4'hF, then load 0x10 -> each rsp_valid arrives 3 cycles after accept; load rdata = 0xDEADBEEF, err = 0.
REQ-036 SHALL cover: store 0x11223344 to 0x20, then store 0xAABBCCDD with be 4'b0101, then load 0x20 -> rdata = 0x11BB33DD.
REQ-037 SHALL cover: load 0x22 (misaligned) and load 4*DEPTH_WORDS (out of range) -> err = 1, rdata = 0; a store to 0x22 leaves word 0x20 unchanged.
REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rdata and err stable; req_ready = 0 throughout; IDLE one cycle after the handshake.
REQ-039 SHALL cover: reset asserted in WAIT during a store of 0xCAFEF00D to 0x30 -> after release req_ready = 1, rsp_valid = 0, and a load of 0x30 returns the previous value.
REQ-040 SHALL cover: WAIT_CYCLES = 0, with back-to-back requests and rsp_ready tied 1 -> rsp_valid one cycle after each accept, one transaction per 2 cycles.
